// File: rtl/facto_queue_core.sv
// Factorial job queue: operands are queued through a 64-bit register port, n! is built one
// multiply per cycle and queued as a result. Define FACTO_OVF_DETECT_EN for saturating overflow.
module facto_queue_core #(
    parameter int OPND_W     = 8,
    parameter int RES_W      = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_sel,
    input  logic        s_wr,
    input  logic [15:0] s_addr,
    input  logic [63:0] s_din,
    output logic [63:0] s_dout,
    output logic        interrupt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, MUL, DONE} state_t;

    state_t             state;
    logic [RES_W-1:0]   acc;
    logic [OPND_W-1:0]  cnt;
    logic [OPND_W-1:0]  job_n;
    logic               pend;

    logic               opstart, opclear, intr_en, drop, ovf;

    logic [OPND_W-1:0]  opnd_mem [FIFO_DEPTH];
    logic [AW-1:0]      opnd_rd, opnd_wr;
    logic [CW-1:0]      opnd_cnt;
    logic [RES_W-1:0]   res_mem [FIFO_DEPTH];
    logic [AW-1:0]      res_rd, res_wr;
    logic [CW-1:0]      res_cnt;

    logic               wr_en;
    logic [2:0]         idx;
    logic               opnd_full, opnd_empty, res_full, res_empty, busy;
    logic               opnd_push_req, opnd_push_ok, deq;
    logic               res_pop_ok, res_can, res_push, mul_last;
    logic [RES_W:0]     mul_res;
    logic [127:0]       head_ext;
    logic [63:0]        status_word;
    logic               unused_bits;

    // Returns {overflow, product}; with detection enabled an overflowing product saturates.
    function automatic logic [RES_W:0] sat_mul(input logic [RES_W-1:0] a,
                                               input logic [OPND_W-1:0] k);
        logic [RES_W+OPND_W-1:0] p;
        logic                    unused_hi;
        p = {{OPND_W{1'b0}}, a} * {{RES_W{1'b0}}, k};
        unused_hi = |p[RES_W+OPND_W-1:RES_W];
`ifdef FACTO_OVF_DETECT_EN
        if (unused_hi) return {1'b1, {RES_W{1'b1}}};
`endif
        return {1'b0, p[RES_W-1:0]};
    endfunction

    assign unused_bits = ^{s_addr[15:6], s_addr[2:0], s_din[63:OPND_W]};

    assign wr_en      = s_sel && s_wr;
    assign idx        = s_addr[5:3];
    assign opnd_full  = (opnd_cnt == CW'(FIFO_DEPTH));
    assign opnd_empty = (opnd_cnt == '0);
    assign res_full   = (res_cnt == CW'(FIFO_DEPTH));
    assign res_empty  = (res_cnt == '0);
    assign busy       = (state != IDLE);

    assign deq           = (state == IDLE) && opstart && !opclear && !opnd_empty;
    assign opnd_push_req = wr_en && (idx == 3'd4) && !opclear;
    // A push into a full queue still lands when the engine frees a slot on the same edge.
    assign opnd_push_ok  = opnd_push_req && (!opnd_full || deq);
    assign res_pop_ok    = wr_en && (idx == 3'd7) && s_din[0] && !res_empty && !opclear;
    assign res_can       = !res_full || res_pop_ok;
    assign mul_last      = (state == MUL) && (cnt <= OPND_W'(1));
    assign res_push      = !opclear && res_can &&
                           (mul_last || ((state == DONE) && pend));
    assign mul_res       = sat_mul(acc, cnt);

    assign head_ext    = 128'(res_mem[res_rd]);
    assign status_word = {48'b0, 8'(res_cnt), 1'b0, ovf, drop,
                          res_full, res_empty, opnd_empty, opnd_full, busy};

    always_comb begin
        s_dout = '0;
        if (s_sel && !s_wr) begin
            case (idx)
                3'd0:    s_dout = {63'b0, opstart};
                3'd1:    s_dout = {63'b0, opclear};
                3'd2:    s_dout = status_word;
                3'd3:    s_dout = {63'b0, intr_en};
                3'd5:    s_dout = res_empty ? 64'b0 : head_ext[127:64];
                3'd6:    s_dout = res_empty ? 64'b0 : head_ext[63:0];
                default: s_dout = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            opstart   <= 1'b0;
            opclear   <= 1'b0;
            intr_en   <= 1'b0;
            drop      <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            if (wr_en && idx == 3'd0) opstart <= s_din[0];
            if (wr_en && idx == 3'd1) opclear <= s_din[0];
            if (wr_en && idx == 3'd3) intr_en <= s_din[0];
            if (opclear)
                drop <= 1'b0;
            else if (opnd_push_req && !opnd_push_ok)
                drop <= 1'b1;
            interrupt <= intr_en && !res_empty;
        end
    end

    always_ff @(posedge clk) begin
        if (opnd_push_ok) opnd_mem[opnd_wr] <= s_din[OPND_W-1:0];
        if (res_push)     res_mem[res_wr]   <= acc;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || opclear) begin
            opnd_rd  <= '0;
            opnd_wr  <= '0;
            opnd_cnt <= '0;
            res_rd   <= '0;
            res_wr   <= '0;
            res_cnt  <= '0;
        end else begin
            if (opnd_push_ok) opnd_wr <= opnd_wr + AW'(1);
            if (deq)          opnd_rd <= opnd_rd + AW'(1);
            opnd_cnt <= opnd_cnt + CW'(opnd_push_ok) - CW'(deq);
            if (res_push)     res_wr <= res_wr + AW'(1);
            if (res_pop_ok)   res_rd <= res_rd + AW'(1);
            res_cnt <= res_cnt + CW'(res_push) - CW'(res_pop_ok);
        end
    end

    // The result is pushed on the edge that leaves MUL; DONE only holds it while the queue is full.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            job_n <= '0;
            pend  <= 1'b0;
            ovf   <= 1'b0;
        end else if (opclear) begin
            state <= IDLE;
            pend  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (deq) begin
                        job_n <= opnd_mem[opnd_rd];
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    acc   <= RES_W'(1);
                    cnt   <= job_n;
                    state <= MUL;
                end
                MUL: begin
                    if (cnt > OPND_W'(1)) begin
                        acc <= mul_res[RES_W-1:0];
                        cnt <= cnt - OPND_W'(1);
                        if (mul_res[RES_W]) ovf <= 1'b1;
                    end else begin
                        pend  <= !res_can;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!pend || res_can) begin
                        pend  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_facto_queue_core.sv
// Bench for facto_queue_core: a 128-bit and a 64-bit instance share one register bus and are
// checked against an exact-arithmetic factorial model (honours FACTO_OVF_DETECT_EN).
`timescale 1ns/1ps
module tb_facto_queue_core;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_sel, s_wr;
    logic [15:0] s_addr;
    logic [63:0] s_din;
    logic [63:0] dout_a, dout_b;
    logic        irq_a, irq_b;

    int   total = 0;
    int   bad   = 0;
    logic m_ovf_a = 1'b0;
    logic m_ovf_b = 1'b0;

    facto_queue_core #(.OPND_W(8), .RES_W(128), .FIFO_DEPTH(4)) u_a (
        .clk(clk), .reset_n(reset_n), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr),
        .s_din(s_din), .s_dout(dout_a), .interrupt(irq_a));

    facto_queue_core #(.OPND_W(8), .RES_W(64), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .reset_n(reset_n), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr),
        .s_din(s_din), .s_dout(dout_b), .interrupt(irq_b));

    always #50 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input int idx, input logic [63:0] data);
        @(negedge clk);
        s_sel = 1'b1; s_wr = 1'b1; s_addr = 16'(idx * 8); s_din = data;
        @(negedge clk);
        s_sel = 1'b0; s_wr = 1'b0; s_din = '0;
    endtask

    task automatic rd(input int idx, output logic [63:0] a, output logic [63:0] b);
        s_sel = 1'b1; s_wr = 1'b0; s_addr = 16'(idx * 8);
        #1;
        a = dout_a; b = dout_b;
        s_sel = 1'b0;
    endtask

    // Exact n! (n <= 40 fits 256 bits), reduced to w bits; o flags a product beyond w bits.
    task automatic model(input int n, input int w, output logic [127:0] r, output logic o);
        logic [255:0] e;
        e = 256'd1;
        for (int k = 2; k <= n; k++) e = e * 256'(k);
        o = (e >> w) != 256'd0;
        r = (w == 64) ? {64'b0, e[63:0]} : e[127:0];
`ifdef FACTO_OVF_DETECT_EN
        if (o) r = (w == 64) ? {64'b0, {64{1'b1}}} : {128{1'b1}};
`else
        o = 1'b0;
`endif
    endtask

    task automatic job(input int n, output logic [63:0] got_a, output logic [63:0] got_b);
        logic [127:0] ea, eb;
        logic         oa, ob;
        logic [63:0]  va, vb;
        int           cyc, lat;
        model(n, 128, ea, oa);
        model(n, 64, eb, ob);
        lat = (n > 1) ? n + 1 : 2;
        wr(4, 64'(n));
        cyc = 0;
        va = '0; vb = '0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            rd(2, va, vb);
            if (va[15:8] != 8'd0) break;
        end
        chk("latency", 128'(cyc - 1), 128'(lat));
        chk("cnt_b", vb[15:8], 1);
        chk("irq_lag", irq_a, 0);
        rd(6, got_a, got_b);
        chk("res_l_a", got_a, ea[63:0]);
        chk("res_l_b", got_b, eb[63:0]);
        rd(5, va, vb);
        chk("res_h_a", va, ea[127:64]);
        chk("res_h_b", vb, 0);
        m_ovf_a = m_ovf_a | oa;
        m_ovf_b = m_ovf_b | ob;
        rd(2, va, vb);
        chk("ovf_a", va[6], m_ovf_a);
        chk("ovf_b", vb[6], m_ovf_b);
        @(negedge clk);
        chk("irq_a", irq_a, 1);
        chk("irq_b", irq_b, 1);
        wr(7, 64'd1);
        @(negedge clk);
        chk("irq_clr", irq_a, 0);
        rd(2, va, vb);
        chk("res_empty", va[3], 1);
    endtask

    initial begin
        logic [63:0] va, vb, ga, gb;
        logic [63:0] exp4 [4];
        int          cyc;

        reset_n = 1'b0; s_sel = 1'b0; s_wr = 1'b0; s_addr = 16'h0010; s_din = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("dout_unsel", dout_a, 0);
        reset_n = 1'b1;
        rd(2, va, vb);
        chk("rst_status_a", va, 64'hC);
        chk("rst_status_b", vb, 64'hC);
        rd(0, va, vb);
        chk("rst_opstart", va, 0);
        rd(3, va, vb);
        chk("rst_intren", va, 0);
        chk("rst_irq", irq_a, 0);

        wr(3, 64'd1);
        wr(0, 64'd1);
        rd(0, va, vb);
        chk("opstart_rb", va, 1);
        rd(3, va, vb);
        chk("intren_rb", va, 1);
        rd(4, va, vb);
        chk("wo_read", va, 0);

        // 20! on both widths, then the trivial factorials
        job(20, ga, gb);
        chk("fact20", ga, 64'h21C3677C82B40000);
        job(0, ga, gb);
        chk("fact0", ga, 1);
        job(1, ga, gb);
        chk("fact1", ga, 1);

        // two queued operands
        wr(4, 64'd0);
        wr(4, 64'd1);
        cyc = 0;
        va = '0;
        while (cyc < 50 && va[15:8] != 8'd2) begin
            @(negedge clk);
            cyc++;
            rd(2, va, vb);
        end
        chk("pair_cnt", va[15:8], 2);
        rd(6, va, vb);
        chk("pair_r0", va, 1);
        wr(7, 64'd1);
        rd(6, va, vb);
        chk("pair_r1", va, 1);
        wr(7, 64'd1);
        rd(2, va, vb);
        chk("pair_empty", va[3], 1);
        @(negedge clk);
        chk("pair_irq", irq_a, 0);

        // overfill the operand queue while stopped
        wr(0, 64'd0);
        for (int i = 0; i < 5; i++) wr(4, 64'(3 + i));
        rd(2, va, vb);
        chk("q_full", va[1], 1);
        chk("q_drop", va[5], 1);
        chk("q_idle", va[0], 0);
        wr(0, 64'd1);
        repeat (80) @(negedge clk);
        rd(2, va, vb);
        chk("q_rcnt", va[15:8], 4);
        chk("q_rfull", va[4], 1);
        chk("q_oempty", va[2], 1);
        exp4[0] = 64'd6; exp4[1] = 64'd24; exp4[2] = 64'd120; exp4[3] = 64'd720;
        for (int i = 0; i < 4; i++) begin
            rd(6, va, vb);
            chk("q_res_a", va, exp4[i]);
            chk("q_res_b", vb, exp4[i]);
            wr(7, 64'd1);
        end
        rd(2, va, vb);
        chk("q_drained", va[15:8], 0);

        // result queue full: engine must hold its result in DONE
        wr(0, 64'd0);
        for (int i = 0; i < 4; i++) wr(4, 64'd2);
        wr(0, 64'd1);
        repeat (40) @(negedge clk);
        wr(4, 64'd3);
        repeat (20) @(negedge clk);
        rd(2, va, vb);
        chk("stall_busy", va[0], 1);
        chk("stall_cnt", va[15:8], 4);
        chk("stall_full", va[4], 1);
        wr(7, 64'd1);
        rd(2, va, vb);
        chk("unstall_busy", va[0], 0);
        chk("unstall_cnt", va[15:8], 4);
        exp4[0] = 64'd2; exp4[1] = 64'd2; exp4[2] = 64'd2; exp4[3] = 64'd6;
        for (int i = 0; i < 4; i++) begin
            rd(6, va, vb);
            chk("stall_res", va, exp4[i]);
            wr(7, 64'd1);
        end

        // opclear during a long job
        rd(2, va, vb);
        chk("drop_sticky", va[5], 1);
        wr(4, 64'd20);
        repeat (5) @(negedge clk);
        rd(2, va, vb);
        chk("clr_busy", va[0], 1);
        wr(1, 64'd1);
        wr(4, 64'd9);
        rd(2, va, vb);
        chk("clr_status_a", va, 64'hC);
        chk("clr_status_b", vb, 64'hC);
        wr(1, 64'd0);
        repeat (30) @(negedge clk);
        rd(2, va, vb);
        chk("clr_after", va, 64'hC);
        chk("clr_irq", irq_a, 0);
        m_ovf_a = 1'b0;
        m_ovf_b = 1'b0;

        for (int i = 0; i < 8; i++) job(int'($urandom_range(0, 40)), ga, gb);
        job(21, ga, gb);
`ifdef FACTO_OVF_DETECT_EN
        chk("fact21_b", gb, {64{1'b1}});
`else
        chk("fact21_b", gb, 64'd14197454024290336768);
`endif
        job(36, ga, gb);

        // reset in the middle of a job
        wr(4, 64'd30);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rd(2, va, vb);
        chk("mid_rst_a", va, 64'hC);
        chk("mid_rst_b", vb, 64'hC);
        rd(0, va, vb);
        chk("mid_rst_opstart", va, 0);
        rd(3, va, vb);
        chk("mid_rst_intren", va, 0);
        chk("mid_rst_irq", irq_a, 0);
        repeat (40) @(negedge clk);
        rd(2, va, vb);
        chk("mid_rst_quiet", va, 64'hC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
